// File: rtl/store_to_fetch_arbiter_pkg.sv
// Shared CPU bus definitions for the store-to-fetch mailbox: sizing defaults,
// the packet type, mailbox state encoding and a small index helper.
package store_to_fetch_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int PKT_W_DEF   = 64;

  typedef logic [PKT_W_DEF-1:0] store_to_fetch_packet_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mailbox_state_t;

  // Next round-robin position after index idx among n requesters.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/store_to_fetch_arbiter_if.sv
// Store-side request bus plus fetch-side mailbox bus of the store-to-fetch arbiter.
// The slave modport is the arbiter's view; master is the requester/fetch view.
interface store_to_fetch_arbiter_if
  import store_to_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PKT_W   = PKT_W_DEF
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][PKT_W-1:0] req_pkt;
  logic [NUM_REQ-1:0]            grant;
  logic                          flush;
  logic                          can_receive;
  logic [PKT_W-1:0]              data;
  logic                          recv;
  logic                          proto_err;

  modport master (
    output req, req_pkt, flush, recv,
    input  grant, can_receive, data, proto_err
  );

  modport slave (
    input  req, req_pkt, flush, recv,
    output grant, can_receive, data, proto_err
  );

endinterface

// File: rtl/store_to_fetch_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping
// modulo NUM_REQ; returns a one-hot grant and the winning index.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/store_to_fetch_arbiter.sv
// One-entry store-to-fetch mailbox with round-robin admission of store requesters.
// Define STORE_FETCH_ARB_PROTO_CHECK_EN to build the sticky protocol-error checker.
module store_to_fetch_arbiter
  import store_to_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PKT_W   = PKT_W_DEF
) (
  input logic                    clk,
  input logic                    reset,
  store_to_fetch_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  mailbox_state_t     state_reg, state_next;
  logic [PKT_W-1:0]   data_reg, data_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   pick_index;
  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] grant;
  logic               grant_en;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .grant  (pick_grant),
    .index  (pick_index)
  );

  // A slot opens when empty or when fetch drains it this same cycle.
  always_comb begin
    grant_en    = !reset && !bus.flush && (state_reg == ST_EMPTY || bus.recv);
    grant       = grant_en ? pick_grant : '0;
    state_next  = state_reg;
    data_next   = data_reg;
    rr_ptr_next = rr_ptr_reg;
    if (|grant) begin
      data_next   = bus.req_pkt[pick_index];
      rr_ptr_next = IDX_W'(wrap_inc(int'(pick_index), NUM_REQ));
    end
    if (bus.flush)     state_next = ST_EMPTY;
    else if (|grant)   state_next = ST_FULL;
    else if (bus.recv) state_next = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_EMPTY;
      data_reg   <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign bus.grant       = grant;
  assign bus.can_receive = (state_reg == ST_FULL);
  assign bus.data        = data_reg;

`ifdef STORE_FETCH_ARB_PROTO_CHECK_EN
  logic               proto_err_reg;
  logic [NUM_REQ-1:0] waiting_reg;

  // A requester left waiting last cycle must still be requesting now.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
      waiting_reg   <= '0;
    end else begin
      waiting_reg <= bus.req & ~grant;
      if ((bus.recv && state_reg == ST_EMPTY) || |(waiting_reg & ~bus.req))
        proto_err_reg <= 1'b1;
    end
  end

  assign bus.proto_err = proto_err_reg;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule
